// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-port memory between an instruction-fetch reader
//           and a load/store unit, LS-first with bounded IF starvation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we_re,
    input  logic [3:0]        i_ls_mask,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_mem_request,
    output logic              o_mem_we_re,
    output logic [3:0]        o_mem_mask,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_in,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_data_out,
    output logic              o_err_timeout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] c_STARVE_MAX   = 4'(STARVE_MAX);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_owner_ls;
    logic         w_owner_nxt;
    logic [3:0]   r_streak;
    logic [3:0]   w_streak_nxt;
    logic [7:0]   r_wait_cnt;
    logic [7:0]   w_wait_cnt_nxt;
    logic         w_window;
    logic         w_issue;
    logic         w_pick_ls;
    logic         w_resp;
    logic         w_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_owner_ls <= 1'b0;
            r_streak   <= 4'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner_ls <= w_owner_nxt;
            r_streak   <= w_streak_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner_ls;
        w_streak_nxt   = r_streak;
        w_wait_cnt_nxt = r_wait_cnt;
        w_window       = 1'b0;
        w_resp         = 1'b0;
        w_timeout      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_window = 1'b1;
            end
            S_WAIT: begin
                if (i_mem_valid) begin
                    w_window    = 1'b1;
                    w_resp      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // LS keeps priority until it has won STARVE_MAX times in a row over a waiting IF
        w_pick_ls = i_ls_req && (!i_if_req || (r_streak != c_STARVE_MAX));
        w_issue   = w_window && (i_if_req || i_ls_req);

        if (w_issue) begin
            w_state_nxt    = S_WAIT;
            w_owner_nxt    = w_pick_ls;
            w_wait_cnt_nxt = 8'd0;
            if (w_pick_ls && i_if_req) begin
                w_streak_nxt = (r_streak == c_STARVE_MAX) ? r_streak : r_streak + 4'd1;
            end else begin
                w_streak_nxt = 4'd0;
            end
        end
    end

    // Everything below is forced to zero while reset is held
    assign o_if_gnt      = rst && w_issue && !w_pick_ls;
    assign o_ls_gnt      = rst && w_issue && w_pick_ls;
    assign o_mem_request = rst && w_issue;
    assign o_mem_we_re   = o_ls_gnt && i_ls_we_re;
    assign o_mem_mask    = o_ls_gnt ? i_ls_mask : (o_if_gnt ? 4'hF : 4'h0);
    assign o_mem_address = o_ls_gnt ? i_ls_addr : (o_if_gnt ? i_if_addr : '0);
    assign o_mem_data_in = o_ls_gnt ? i_ls_wdata : '0;

    assign o_if_rvalid   = rst && w_resp && !r_owner_ls;
    assign o_ls_rvalid   = rst && w_resp && r_owner_ls;
    assign o_if_rdata    = o_if_rvalid ? i_mem_data_out : '0;
    assign o_ls_rdata    = o_ls_rvalid ? i_mem_data_out : '0;
    assign o_err_timeout = rst && w_timeout;

endmodule

`default_nettype wire
